// File: rtl/fx_cmd_decoder.sv
// Host byte-stream command decoder: turns CMD/A2/A1/A0/LEN packets into fx bus
// register writes and reads, and streams read data back to the host.
module fx_cmd_decoder #(
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] fx_waddr,
  output logic              fx_wr,
  output logic [7:0]        fx_data,
  output logic              fx_rd,
  output logic [ADDR_W-1:0] fx_raddr,
  input  logic [7:0]        fx_q,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR2, S_ADDR1, S_ADDR0, S_LEN, S_WDATA, S_RREQ, S_RWAIT, S_RSEND
  } state_t;

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] base;
  logic [7:0]        len;
  logic [7:0]        idx;
  logic [2:0]        lat_cnt;
  logic              cmd_wr;

  logic rx_hs;
  logic in_pkt;
  logic tmo_hit;
  logic cmd_ok;
  logic err_inc;

  always_comb begin
    in_pkt   = state inside {S_ADDR2, S_ADDR1, S_ADDR0, S_LEN, S_WDATA};
    rx_ready = in_pkt || (state == S_IDLE);
    rx_hs    = rx_valid && rx_ready;
    cmd_ok   = (rx_data == 8'h57) || (rx_data == 8'h52);
    // A byte arriving on the last allowed cycle wins over the timeout.
    tmo_hit  = in_pkt && !rx_hs && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    err_inc  = tmo_hit || ((state == S_IDLE) && rx_hs && !cmd_ok);
    busy     = (state != S_IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= S_IDLE;
      tmo_cnt  <= '0;
      base     <= '0;
      len      <= '0;
      idx      <= '0;
      lat_cnt  <= '0;
      cmd_wr   <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      fx_waddr <= '0;
      fx_wr    <= 1'b0;
      fx_data  <= '0;
      fx_rd    <= 1'b0;
      fx_raddr <= '0;
      err_cnt  <= '0;
    end else begin
      fx_wr <= 1'b0;
      fx_rd <= 1'b0;

      if (err_inc && (err_cnt != '1))
        err_cnt <= err_cnt + 8'd1;

      if (!in_pkt || rx_hs || tmo_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (tmo_hit) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_hs && cmd_ok) begin
              cmd_wr <= (rx_data == 8'h57);
              state  <= S_ADDR2;
            end
          end
          // Address bytes shift in MSB first; bits above ADDR_W fall off the top.
          S_ADDR2: if (rx_hs) begin
            base  <= ADDR_W'(rx_data);
            state <= S_ADDR1;
          end
          S_ADDR1: if (rx_hs) begin
            base  <= ADDR_W'({base, rx_data});
            state <= S_ADDR0;
          end
          S_ADDR0: if (rx_hs) begin
            base  <= ADDR_W'({base, rx_data});
            state <= S_LEN;
          end
          S_LEN: if (rx_hs) begin
            len <= rx_data;
            idx <= '0;
            if (cmd_wr) begin
              state <= S_WDATA;
            end else begin
              fx_rd    <= 1'b1;
              fx_raddr <= base;
              state    <= S_RREQ;
            end
          end
          S_WDATA: if (rx_hs) begin
            fx_wr    <= 1'b1;
            fx_data  <= rx_data;
            fx_waddr <= base + ADDR_W'(idx);
            if (idx == len)
              state <= S_IDLE;
            else
              idx <= idx + 8'd1;
          end
          S_RREQ: begin
            lat_cnt <= 3'd1;
            state   <= S_RWAIT;
          end
          S_RWAIT: begin
            if (lat_cnt == 3'(RD_LAT)) begin
              tx_data  <= fx_q;
              tx_valid <= 1'b1;
              state    <= S_RSEND;
            end else begin
              lat_cnt <= lat_cnt + 3'd1;
            end
          end
          S_RSEND: if (tx_ready) begin
            tx_valid <= 1'b0;
            if (idx == len) begin
              state <= S_IDLE;
            end else begin
              idx      <= idx + 8'd1;
              fx_rd    <= 1'b1;
              fx_raddr <= base + ADDR_W'(idx + 8'd1);
              state    <= S_RREQ;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fx_cmd_decoder.sv
// Bench for fx_cmd_decoder: directed packets plus randomized traffic compared
// against a packet-level model of expected fx writes, reads and tx bytes.
module tb_fx_cmd_decoder;

  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned RD_LAT  = 3;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned AMASK   = (32'd1 << ADDR_W) - 32'd1;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] fx_waddr;
  logic              fx_wr;
  logic [7:0]        fx_data;
  logic              fx_rd;
  logic [ADDR_W-1:0] fx_raddr;
  logic [7:0]        fx_q;
  logic              busy;
  logic [7:0]        err_cnt;

  fx_cmd_decoder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Register file behind the fx bus: data is only valid RD_LAT cycles after fx_rd.
  function automatic logic [7:0] qval(input int unsigned a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'(a >> 16) ^ 8'h3C;
  endfunction

  logic [7:0]  pv = '0;
  int unsigned pa [0:7];
  logic [7:0]  junk = '0;

  always @(posedge clk) begin
    pv    <= {pv[6:0], fx_rd};
    pa[0] <= 32'(fx_raddr);
    for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    junk  <= 8'($urandom);
  end

  always_comb fx_q = pv[RD_LAT-1] ? qval(pa[RD_LAT-1]) : junk;

  logic tx_stall = 1'b1;
  always @(posedge clk) begin
    #1;
    tx_ready = !tx_stall && ($urandom_range(3, 0) != 0);
  end

  logic [31:0] got_wr[$], exp_wr[$], got_rd[$], exp_rd[$], got_tx[$], exp_tx[$];
  int unsigned exp_err = 0;
  logic [7:0]  wdat[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (fx_wr) got_wr.push_back({2'b00, fx_waddr, fx_data});
      if (fx_rd) got_rd.push_back({10'd0, fx_raddr});
      if (tx_valid && tx_ready) got_tx.push_back({24'd0, tx_data});
    end
  end

  task automatic compare_all(input string tag);
    check_eq({tag, "_nwr"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      check_eq({tag, "_wr"}, got_wr[i], exp_wr[i]);
    check_eq({tag, "_nrd"}, 32'(got_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
      check_eq({tag, "_rd"}, got_rd[i], exp_rd[i]);
    check_eq({tag, "_ntx"}, 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      check_eq({tag, "_tx"}, got_tx[i], exp_tx[i]);
    check_eq({tag, "_err"}, 32'(err_cnt), exp_err);
    got_wr.delete(); exp_wr.delete();
    got_rd.delete(); exp_rd.delete();
    got_tx.delete(); exp_tx.delete();
  endtask

  task automatic model_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic push_write(input int unsigned base, input int unsigned i, input logic [7:0] d);
    exp_wr.push_back((((base + i) & AMASK) << 8) | 32'(d));
  endtask

  task automatic push_read(input int unsigned base, input int unsigned i);
    exp_rd.push_back((base + i) & AMASK);
    exp_tx.push_back(32'(qval((base + i) & AMASK)));
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n;
    logic hs;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 3000) begin
      @(negedge clk);
      hs = rx_ready;
      @(posedge clk); #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!hs) check_eq("rx_hs_bound", 32'(hs), 32'd1);
  endtask

  task automatic send_header(input logic [7:0] cmd, input int unsigned a24,
                             input int unsigned len, input int unsigned maxgap);
    send_byte(cmd, $urandom_range(maxgap, 0));
    send_byte(8'(a24 >> 16), $urandom_range(maxgap, 0));
    send_byte(8'(a24 >> 8), $urandom_range(maxgap, 0));
    send_byte(8'(a24), $urandom_range(maxgap, 0));
    send_byte(8'(len), $urandom_range(maxgap, 0));
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (busy && n < 5000) begin @(posedge clk); #1; n++; end
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_packet(input string tag, input bit is_wr, input int unsigned a24,
                             input int unsigned len, input int unsigned maxgap);
    int unsigned base = a24 & AMASK;
    logic [7:0] d;
    send_header(is_wr ? 8'h57 : 8'h52, a24, len, maxgap);
    for (int unsigned i = 0; i <= len; i++) begin
      if (is_wr) begin
        d = (wdat.size() != 0) ? wdat.pop_front() : 8'($urandom);
        push_write(base, i, d);
        send_byte(d, $urandom_range(maxgap, 0));
      end else begin
        push_read(base, i);
      end
    end
    wait_idle(tag);
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq({tag, "_fx_wr"}, 32'(fx_wr), 32'd0);
    check_eq({tag, "_fx_rd"}, 32'(fx_rd), 32'd0);
    check_eq({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check_eq({tag, "_fx_waddr"}, 32'(fx_waddr), 32'd0);
    check_eq({tag, "_fx_raddr"}, 32'(fx_raddr), 32'd0);
    check_eq({tag, "_fx_data"}, 32'(fx_data), 32'd0);
    check_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    exp_err = 0;
    got_wr.delete(); got_rd.delete(); got_tx.delete();
    exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0]  d, b;
    logic        held, rr_low;
    int unsigned n;

    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    tx_stall = 1'b0;
    do_reset("por");

    wdat = '{8'hAA, 8'hBB};
    send_packet("wr_burst", 1'b1, 32'h001000, 1, 0);
    send_packet("rd_burst", 1'b0, 32'h000020, 2, 0);

    // Host holds off the first read byte for 10 cycles.
    tx_stall = 1'b1;
    send_header(8'h52, 32'h000030, 1, 0);
    push_read(32'h30, 0); push_read(32'h30, 1);
    n = 0;
    while (!tx_valid && n < 100) begin @(posedge clk); #1; n++; end
    check_eq("bp_valid", 32'(tx_valid), 32'd1);
    d = tx_data; held = 1'b1; rr_low = 1'b1;
    repeat (10) begin
      @(negedge clk);
      held   = held && tx_valid && (tx_data == d);
      rr_low = rr_low && !rx_ready;
    end
    check_eq("bp_data", 32'(d), 32'(qval(32'h30)));
    check_eq("bp_hold", 32'(held), 32'd1);
    check_eq("bp_rx_ready", 32'(rr_low), 32'd1);
    check_eq("bp_single_rd", 32'(got_rd.size()), 32'd1);
    @(posedge clk); #1;
    tx_stall = 1'b0;
    wait_idle("bp");
    compare_all("bp");

    wdat = '{8'h11, 8'h22};
    send_packet("wrap", 1'b1, 32'hFFFFFF, 1, 1);

    send_byte(8'h00, 0);
    model_err();
    wdat = '{8'h33};
    send_packet("bad_cmd", 1'b1, 32'h000000, 0, 0);

    // Longest allowed gap inside a write still completes it.
    send_header(8'h57, 32'h000040, 0, 0);
    push_write(32'h40, 0, 8'h44);
    send_byte(8'h44, TIMEOUT - 1);
    wait_idle("gap_max");
    compare_all("gap_max");

    // One more idle cycle aborts; the next byte is a fresh command.
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    send_byte(8'h52, TIMEOUT);
    model_err();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h20, 0); send_byte(8'h02, 0);
    for (int unsigned i = 0; i < 3; i++) push_read(32'h20, i);
    wait_idle("timeout");
    compare_all("timeout");

    send_header(8'h57, 32'h000050, 3, 0);
    push_write(32'h50, 0, 8'h01);
    send_byte(8'h01, 0);
    @(posedge clk); #1;
    compare_all("wd_pre");
    do_reset("rst_wdata");
    send_packet("after_rst_wdata", 1'b1, 32'h000050, 3, 1);

    tx_stall = 1'b1;
    send_header(8'h52, 32'h000100, 2, 0);
    exp_rd.push_back(32'h100);
    n = 0;
    while (!tx_valid && n < 100) begin @(posedge clk); #1; n++; end
    check_eq("rs_valid", 32'(tx_valid), 32'd1);
    compare_all("rs_pre");
    do_reset("rst_rsend");
    tx_stall = 1'b0;
    send_packet("after_rst_rsend", 1'b0, 32'h000100, 2, 1);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(7, 0) == 0) begin
        do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
        send_byte(b, $urandom_range(2, 0));
        model_err();
        wait_idle("rnd_junk");
        compare_all("rnd_junk");
      end else begin
        send_packet("rnd", ($urandom_range(1, 0) == 1),
                    ($urandom_range(3, 0) == 0) ? (32'hFFFFFF - $urandom_range(3, 0))
                                                : ($urandom & 32'hFFFFFF),
                    $urandom_range(5, 0), 3);
      end
    end

    send_packet("long_wr", 1'b1, 32'h3FFF80, 255, 0);

    for (int k = 0; k < 260; k++) begin
      do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
      send_byte(b, 0);
      model_err();
    end
    wait_idle("sat");
    check_eq("err_sat", 32'(err_cnt), 32'd255);
    compare_all("sat");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fx_cmd_decoder.md
Name: fx_cmd_decoder

Overview:
Upstream stage of control_top. Parses the host byte stream arriving from the FX2 slave-FIFO interface into fx bus transactions: register writes (fx_wr/fx_waddr/fx_data) and register reads (fx_rd/fx_raddr). Read results returned on fx_q are serialized back to the host on a byte stream with valid/ready handshake. Supports burst packets with address auto-increment, an inter-byte timeout, and a saturating error counter.

Parameters:
ADDR_W, 22, fx bus address width
RD_LAT, 1, cycles from the fx_rd pulse to valid fx_q; range 1..7
TIMEOUT, 65535, idle cycles allowed between packet bytes before the packet is aborted; minimum 2

Ports:
clk_sys  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
rx_data  in  8  host byte in
rx_valid  in  1  rx_data valid
rx_ready  out  1  decoder accepts a byte; handshake occurs when rx_valid and rx_ready are both high
tx_data  out  8  read-back byte to host
tx_valid  out  1  tx_data valid
tx_ready  in  1  host accepts a byte
fx_waddr  out  ADDR_W  write address
fx_wr  out  1  write strobe, one cycle
fx_data  out  8  write data
fx_rd  out  1  read strobe, one cycle
fx_raddr  out  ADDR_W  read address
fx_q  in  8  read data from control_top
busy  out  1  high in any state other than IDLE
err_cnt  out  8  saturating error count

Behaviour:
- Packet format: CMD, A2, A1, A0, LEN, then data bytes if the packet is a write.
  - CMD: 0x57 = write, 0x52 = read.
  - Base address = {A2,A1,A0}[ADDR_W-1:0]; bits above ADDR_W are ignored.
  - LEN gives LEN+1 transfers (1..256).
  - Transfer i uses address base+i, modulo 2^ADDR_W (wraps 0x3FFFFF -> 0x000000).
- States: IDLE, ADDR2, ADDR1, ADDR0, LEN, WDATA, RREQ, RWAIT, RSEND.
- rx_ready is combinational: 1 in IDLE, ADDR2, ADDR1, ADDR0, LEN and WDATA; 0 in RREQ, RWAIT and RSEND.
- IDLE:
  - Handshaked 0x57 or 0x52 latches the command and moves to ADDR2.
  - Any other byte is consumed, err_cnt increments, and the state stays IDLE.
- ADDR2 -> ADDR1 -> ADDR0 -> LEN: one state per handshaked byte. After LEN, a write goes to WDATA and a read goes to RREQ.
- WDATA write timing:
  - Each handshaked byte registers fx_data = byte and fx_waddr = base+i.
  - fx_wr is high exactly in the cycle after the handshake.
  - The next byte may be accepted in that same cycle, so back-to-back strobes are legal.
  - After byte LEN+1 the state returns to IDLE.
  - fx_waddr and fx_data hold their values until the next write.
- RREQ: fx_rd high for one cycle with fx_raddr = base+i, then go to RWAIT.
- RWAIT:
  - If fx_rd was high in cycle T, fx_q is sampled at the end of cycle T+RD_LAT.
  - The sampled byte goes into tx_data, tx_valid is set, and the state moves to RSEND.
- RSEND:
  - tx_valid and tx_data are held stable until tx_ready.
  - On the handshake tx_valid drops. If i < LEN, go to RREQ with i+1; otherwise go to IDLE.
  - No new fx_rd is issued while a byte is pending.
- Timeout:
  - A counter clears on every rx handshake and on entering ADDR2.
  - It counts only in ADDR2, ADDR1, ADDR0, LEN and WDATA.
  - When it reaches TIMEOUT: return to IDLE, err_cnt increments, and the partial packet is discarded. Writes already strobed are not undone.
  - There is no timeout in the read states; the host may stall tx_ready indefinitely.
- err_cnt saturates at 255. An unknown CMD and a timeout in the same cycle cannot occur; at most one increment per cycle.
- Reset (any cycle, including mid-packet):
  - state = IDLE; fx_wr, fx_rd and tx_valid = 0.
  - fx_waddr, fx_raddr, fx_data, tx_data = 0; err_cnt = 0.
  - Timeout counter and transfer index = 0.
  - rx_ready is 1 in the first cycle after reset deassertion.
- No rx byte is ever lost or double-counted: a byte is consumed only on a handshake.

Test Plan:
- Write burst: rx 57 00 10 00 01 AA BB -> two fx_wr pulses: 0x001000/0xAA then 0x001001/0xBB; fx_rd never asserted; err_cnt = 0.
- Read burst: rx 52 00 00 20 02, fx_q tied to 0x5A -> fx_rd at 0x20, 0x21, 0x22; tx stream 5A 5A 5A; busy falls after the last tx handshake.
- Backpressure: same read with tx_ready low for 10 cycles on the first byte -> tx_valid and tx_data=0x5A held; no second fx_rd until the handshake; rx_ready stays 0.
- Wrap and address truncation: rx 57 FF FF FF 01 11 22 -> writes 0x3FFFFF/0x11 then 0x000000/0x22.
- Errors: rx 00 then 57 00 00 00 00 33 -> err_cnt = 1, then one write 0x000000/0x33. With TIMEOUT=16, rx 57 00 then 16 idle cycles -> IDLE, err_cnt = 2, next byte 52 parsed as CMD.
- Reset mid-operation: assert rst during WDATA after the first data byte, and separately during RSEND -> outputs return to reset values next edge; the following complete packet executes correctly.
